// File: rtl/display_bank_ctrl_pkg.sv
// display_pkg: shared types and helpers for display bank controllers.
package display_pkg;
  typedef enum logic {IDLE, CLEAR} state_t;
  typedef struct packed {
    logic        hit;
    logic [31:0] ch;
  } dec_t;
  localparam logic [31:0] DEF_CLEAR_ADDR = 32'h1800;
  function automatic logic [63:0] fmt_word(input logic [63:0] v);
    return (v << 8) | 64'd1;
  endfunction
  function automatic dec_t ch_decode(input logic [31:0] addr, input logic [31:0] base,
                                     input int stride, input int num);
    dec_t r;
    logic [31:0] off;
    off = addr - base;
    r.ch = off / 32'(stride);
    r.hit = (off % 32'(stride)) == 32'd0 && r.ch < 32'(num);
    return r;
  endfunction
endpackage

// File: rtl/display_bank_ctrl_rr_dirty_arbiter.sv
// rr_dirty_arbiter: first set bit of dirty_i at or after rr_ptr_i, with wrap.
module rr_dirty_arbiter #(
  parameter int N = 16,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] dirty_i,
  input  logic [W-1:0] rr_ptr_i,
  output logic         found_o,
  output logic [W-1:0] idx_o
);
  logic [N-1:0] rot;
  always_comb begin
    rot = N'({dirty_i, dirty_i} >> rr_ptr_i);
    found_o = 1'b0;
    idx_o = '0;
    for (int j = N - 1; j >= 0; j--) begin
      if (rot[j]) begin
        found_o = 1'b1;
        idx_o = W'((int'(rr_ptr_i) + j) % N);
      end
    end
  end
endmodule

// File: rtl/display_bank_ctrl.sv
// display_bank_ctrl: registered display channel bank with broadcast clear sweep
// and round-robin dirty-channel scan-out.
module display_bank_ctrl
  import display_pkg::*;
#(
  parameter int          NUM_CH      = 16,
  parameter int          DATA_W      = 32,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int          ADDR_STRIDE = 4,
  parameter logic [31:0] CLEAR_ADDR  = DEF_CLEAR_ADDR,
  localparam int         CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [31:0]              wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  output logic                     wr_ready,
  output logic                     busy,
  output logic [NUM_CH*DATA_W-1:0] ch_out,
  output logic [NUM_CH-1:0]        ch_dirty,
  output logic                     scan_valid,
  input  logic                     scan_ready,
  output logic [CH_W-1:0]          scan_ch,
  output logic [DATA_W-1:0]        scan_data
);
  state_t              state_q;
  logic [DATA_W-1:0]   ch_q [NUM_CH];
  logic [NUM_CH-1:0]   dirty_q, dirty_d, set_v, arb_in, cur_oh;
  logic [CH_W-1:0]     idx_q, scan_ch_q, rr_q, pick;
  logic [DATA_W-1:0]   scan_data_q, wval;
  logic                scan_valid_q, stale_q, found, hs, take, clr_go, st_go;
  dec_t                dec;

  assign busy = state_q == CLEAR;
  assign wr_ready = !busy;
  assign dec = ch_decode(wr_addr, BASE_ADDR, ADDR_STRIDE, NUM_CH);
  assign clr_go = wr_en && !busy && wr_addr == CLEAR_ADDR;
  assign st_go = wr_en && !busy && !clr_go && dec.hit;
  assign wval = busy ? '0 : DATA_W'(fmt_word(64'(wr_data)));
  assign hs = scan_valid_q && scan_ready;
  assign take = !scan_valid_q || hs;
  assign cur_oh = NUM_CH'(1) << scan_ch_q;

  // stale_q: the presented snapshot has been overwritten, so its channel must stay dirty
  always_comb begin
    for (int i = 0; i < NUM_CH; i++)
      set_v[i] = (st_go && dec.ch == 32'(i)) || (busy && idx_q == CH_W'(i));
    arb_in = hs ? dirty_q & ~cur_oh : dirty_q;
    dirty_d = ((hs && !stale_q) ? dirty_q & ~cur_oh : dirty_q) | set_v;
  end

  rr_dirty_arbiter #(.N(NUM_CH), .W(CH_W)) u_arb (
    .dirty_i (arb_in),
    .rr_ptr_i(rr_q),
    .found_o (found),
    .idx_o   (pick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) ch_q[i] <= '0;
      dirty_q <= '0;
      state_q <= IDLE;
      idx_q <= '0;
      scan_valid_q <= 1'b0;
      scan_ch_q <= '0;
      scan_data_q <= '0;
      rr_q <= '0;
      stale_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) if (set_v[i]) ch_q[i] <= wval;
      dirty_q <= dirty_d;
      if (clr_go) begin
        state_q <= CLEAR;
        idx_q <= '0;
      end else if (busy) begin
        idx_q <= idx_q + 1'b1;
        if (idx_q == CH_W'(NUM_CH - 1)) state_q <= IDLE;
      end
      if (take) begin
        scan_valid_q <= found;
        stale_q <= found && set_v[pick];
        if (found) begin
          scan_ch_q <= pick;
          scan_data_q <= ch_q[pick];
          rr_q <= (pick == CH_W'(NUM_CH - 1)) ? '0 : pick + 1'b1;
        end
      end else begin
        stale_q <= stale_q || set_v[scan_ch_q];
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_out
    assign ch_out[g*DATA_W +: DATA_W] = ch_q[g];
  end
  assign ch_dirty = dirty_q;
  assign scan_valid = scan_valid_q;
  assign scan_ch = scan_ch_q;
  assign scan_data = scan_data_q;
endmodule

// File: tb/tb_display_bank_ctrl.sv
// tb_display_bank_ctrl: randomized and directed checks against a version-tracking bank model.
module tb_display_bank_ctrl;
  localparam int N = 16, W = 32;
  logic clk = 1'b0, rst, wr_en, scan_ready, wr_ready, busy, scan_valid;
  logic [31:0] wr_addr;
  logic [W-1:0] wr_data, scan_data;
  logic [N*W-1:0] ch_out;
  logic [N-1:0] ch_dirty;
  logic [3:0] scan_ch;
  int total = 0, bad = 0;
  logic [W-1:0] m_val [N];
  bit m_dirty [N];
  int m_ver [N];
  bit m_busy, m_sv;
  int m_idx, m_sch, m_sver, m_rr;
  logic [W-1:0] m_sdata;
  int d_ch [$];
  logic [W-1:0] d_data [$];

  display_bank_ctrl dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(wr_ready), .busy(busy), .ch_out(ch_out), .ch_dirty(ch_dirty),
    .scan_valid(scan_valid), .scan_ready(scan_ready), .scan_ch(scan_ch), .scan_data(scan_data)
  );

  always #5 clk = ~clk;

  task automatic m_reset();
    for (int i = 0; i < N; i++) begin m_val[i] = '0; m_dirty[i] = 0; m_ver[i] = 0; end
    m_busy = 0; m_sv = 0; m_idx = 0; m_sch = 0; m_sver = 0; m_rr = 0; m_sdata = '0;
  endtask

  function automatic logic [N*W-1:0] m_chout();
    logic [N*W-1:0] r;
    for (int i = 0; i < N; i++) r[i*W +: W] = m_val[i];
    return r;
  endfunction

  function automatic logic [N-1:0] m_dv();
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = m_dirty[i];
    return r;
  endfunction

  // Every write bumps a channel version; an accepted entry retires dirty only if its version is current.
  task automatic m_edge();
    bit hs, take, start_clr;
    int pick, wc, c, sn_ver;
    logic [W-1:0] wv, sn_val;
    hs = m_sv && scan_ready; take = !m_sv || hs;
    pick = -1; wc = -1; start_clr = 0; wv = '0; sn_val = '0; sn_ver = 0;
    if (take)
      for (int j = 0; j < N; j++) begin
        c = (m_rr + j) % N;
        if (pick < 0 && m_dirty[c] && !(hs && c == m_sch)) pick = c;
      end
    if (pick >= 0) begin sn_val = m_val[pick]; sn_ver = m_ver[pick]; end
    if (m_busy) wc = m_idx;
    else if (wr_en && wr_addr == 32'h1800) start_clr = 1;
    else if (wr_en && wr_addr % 4 == 0 && wr_addr / 4 < N) begin
      wc = int'(wr_addr / 4);
      wv = (wr_data << 8) | W'(1);
    end
    if (wc >= 0) begin m_val[wc] = wv; m_dirty[wc] = 1; m_ver[wc]++; end
    if (hs && m_sver == m_ver[m_sch]) m_dirty[m_sch] = 0;
    if (take) begin
      m_sv = pick >= 0;
      if (pick >= 0) begin m_sch = pick; m_sdata = sn_val; m_sver = sn_ver; m_rr = (pick + 1) % N; end
    end
    if (m_busy) begin m_idx++; if (m_idx == N) m_busy = 0; end
    else if (start_clr) begin m_busy = 1; m_idx = 0; end
  endtask

  task automatic step(input bit we, input logic [31:0] a, input logic [W-1:0] d, input bit rdy);
    wr_en = we; wr_addr = a; wr_data = d; scan_ready = rdy;
    if (scan_valid && scan_ready) begin d_ch.push_back(int'(scan_ch)); d_data.push_back(scan_data); end
    @(posedge clk);
    m_edge();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_en = 0; wr_addr = '0; wr_data = '0; scan_ready = 0;
    m_reset();
    repeat (2) @(negedge clk);
    total++; if (ch_out !== '0) begin bad++; $display("FAIL reset ch_out got=%h exp=0", ch_out); end
    total++; if (ch_dirty !== '0) begin bad++; $display("FAIL reset ch_dirty got=%h exp=0", ch_dirty); end
    total++; if ({busy, wr_ready, scan_valid} !== 3'b010) begin bad++; $display("FAIL reset busy/ready/valid got=%b exp=010", {busy, wr_ready, scan_valid}); end
    total++; if (scan_ch !== '0 || scan_data !== '0) begin bad++; $display("FAIL reset scan got=%0d/%h exp=0/0", scan_ch, scan_data); end
    rst = 1'b0;
  endtask

  task automatic test_store();
    step(1, 32'd8, 32'hAB, 0);
    total++; if (ch_out[2*W +: W] !== 32'h0000AB01) begin bad++; $display("FAIL store ch2 got=%h exp=0000ab01", ch_out[2*W +: W]); end
    total++; if (ch_dirty !== 16'h0004) begin bad++; $display("FAIL store dirty got=%h exp=0004", ch_dirty); end
    total++; if (scan_valid !== 1'b0) begin bad++; $display("FAIL store early valid got=%b exp=0", scan_valid); end
    step(0, 32'd0, 0, 0);
    total++; if (scan_valid !== 1'b1 || scan_ch !== 4'd2 || scan_data !== 32'h0000AB01) begin
      bad++; $display("FAIL store scan got=%b/%0d/%h exp=1/2/0000ab01", scan_valid, scan_ch, scan_data); end
    step(0, 32'd0, 0, 1);
    total++; if (scan_valid !== 1'b0 || ch_dirty !== '0) begin bad++; $display("FAIL store drain got=%b/%h exp=0/0", scan_valid, ch_dirty); end
  endtask

  task automatic test_bad_addr();
    logic [N*W-1:0] o;
    logic [N-1:0] dv;
    o = ch_out; dv = ch_dirty;
    step(1, 32'd2, 32'h11, 0);
    total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL bad_addr wr_ready got=%b exp=1", wr_ready); end
    step(1, 32'd4 * N, 32'h22, 0);
    total++; if (ch_out !== o || ch_dirty !== dv || wr_ready !== 1'b1) begin
      bad++; $display("FAIL bad_addr state dirty got=%h exp=%h ready=%b", ch_dirty, dv, wr_ready); end
  endtask

  task automatic test_fill();
    logic [W-1:0] v [N];
    d_ch.delete(); d_data.delete();
    for (int i = 0; i < N; i++) begin v[i] = W'($urandom); step(1, 32'(4 * i), v[i], 1); end
    repeat (20) step(0, 32'd0, 0, 1);
    total++; if (d_ch.size() != N) begin bad++; $display("FAIL fill count got=%0d exp=%0d", d_ch.size(), N); end
    for (int i = 0; i < N && i < d_ch.size(); i++) begin
      total++; if (d_ch[i] != i || d_data[i] !== ((v[i] << 8) | W'(1))) begin
        bad++; $display("FAIL fill entry %0d got=%0d/%h exp=%0d/%h", i, d_ch[i], d_data[i], i, (v[i] << 8) | W'(1)); end
    end
    total++; if (scan_valid !== 1'b0 || ch_dirty !== '0) begin bad++; $display("FAIL fill end got=%b/%h exp=0/0", scan_valid, ch_dirty); end
  endtask

  task automatic test_clear();
    logic [N-1:0] seen;
    int zeros;
    d_ch.delete(); d_data.delete();
    step(1, 32'h1800, 0, 1);
    for (int c = 0; c < N; c++) begin
      total++; if (busy !== 1'b1 || wr_ready !== 1'b0) begin bad++; $display("FAIL clear busy c=%0d got=%b/%b exp=1/0", c, busy, wr_ready); end
      step(c == 5, 32'd12, 32'h55, 1);
    end
    total++; if (busy !== 1'b0 || wr_ready !== 1'b1) begin bad++; $display("FAIL clear end got=%b/%b exp=0/1", busy, wr_ready); end
    total++; if (ch_out !== '0) begin bad++; $display("FAIL clear ch_out got=%h exp=0", ch_out); end
    repeat (30) step(0, 32'd0, 0, 1);
    seen = '0; zeros = 0;
    foreach (d_ch[i]) if (d_data[i] === '0) begin zeros++; seen[d_ch[i]] = 1'b1; end
    total++; if (zeros != N || seen !== '1) begin bad++; $display("FAIL clear scan zeros got=%0d/%h exp=%0d/ffff", zeros, seen, N); end
  endtask

  task automatic test_same_cycle();
    d_ch.delete(); d_data.delete();
    step(1, 32'd20, 32'h3, 0);
    repeat (3) begin
      step(0, 32'd0, 0, 0);
      total++; if (scan_valid !== 1'b1 || scan_ch !== 4'd5 || scan_data !== 32'h301) begin
        bad++; $display("FAIL same hold got=%b/%0d/%h exp=1/5/301", scan_valid, scan_ch, scan_data); end
    end
    step(1, 32'd20, 32'h7, 1);
    total++; if (d_data.size() != 1 || d_data[0] !== 32'h301) begin bad++; $display("FAIL same accepted got=%0d entries exp=1 old value 301", d_data.size()); end
    total++; if (ch_dirty[5] !== 1'b1 || ch_out[5*W +: W] !== 32'h701) begin bad++; $display("FAIL same dirty got=%b/%h exp=1/701", ch_dirty[5], ch_out[5*W +: W]); end
    step(0, 32'd0, 0, 0);
    total++; if (scan_valid !== 1'b1 || scan_ch !== 4'd5 || scan_data !== 32'h701) begin
      bad++; $display("FAIL same reemit got=%b/%0d/%h exp=1/5/701", scan_valid, scan_ch, scan_data); end
    step(0, 32'd0, 0, 1);
    total++; if (ch_dirty !== '0 || scan_valid !== 1'b0) begin bad++; $display("FAIL same drain got=%h/%b exp=0/0", ch_dirty, scan_valid); end
  endtask

  task automatic test_async_reset();
    step(1, 32'd36, 32'h9A, 0);
    step(1, 32'h1800, 0, 0);
    repeat (7) step(0, 32'd0, 0, 0);
    #2 rst = 1'b1;
    #1;
    m_reset();
    total++; if (ch_out !== '0 || ch_dirty !== '0) begin bad++; $display("FAIL arst data got dirty=%h exp=0", ch_dirty); end
    total++; if ({busy, wr_ready, scan_valid} !== 3'b010 || scan_ch !== '0 || scan_data !== '0) begin
      bad++; $display("FAIL arst ctrl got=%b ch=%0d data=%h exp=010/0/0", {busy, wr_ready, scan_valid}, scan_ch, scan_data); end
    @(negedge clk) rst = 1'b0;
    repeat (3) step(0, 32'd0, 0, 1);
    total++; if (wr_ready !== 1'b1 || busy !== 1'b0 || ch_dirty !== '0) begin
      bad++; $display("FAIL arst resume got=%b/%b/%h exp=1/0/0", wr_ready, busy, ch_dirty); end
  endtask

  task automatic test_random();
    logic [31:0] a;
    int r;
    for (int cyc = 0; cyc < 400; cyc++) begin
      r = int'($urandom_range(0, 99));
      a = r < 70 ? 32'(4 * $urandom_range(0, N - 1)) : r < 78 ? 32'h1800 : r < 90 ? 32'($urandom_range(0, 127)) : $urandom;
      step($urandom_range(0, 1) == 1, a, W'($urandom), $urandom_range(0, 2) != 0);
      total++; if (ch_out !== m_chout()) begin bad++; $display("FAIL rand ch_out cyc=%0d got=%h exp=%h", cyc, ch_out, m_chout()); end
      total++; if (ch_dirty !== m_dv()) begin bad++; $display("FAIL rand dirty cyc=%0d got=%h exp=%h", cyc, ch_dirty, m_dv()); end
      total++; if (busy !== m_busy || wr_ready !== !m_busy) begin bad++; $display("FAIL rand busy cyc=%0d got=%b/%b exp=%b", cyc, busy, wr_ready, m_busy); end
      total++; if (scan_valid !== m_sv) begin bad++; $display("FAIL rand valid cyc=%0d got=%b exp=%b", cyc, scan_valid, m_sv); end
      total++; if (scan_ch !== 4'(m_sch) || scan_data !== m_sdata) begin
        bad++; $display("FAIL rand scan cyc=%0d got=%0d/%h exp=%0d/%h", cyc, scan_ch, scan_data, m_sch, m_sdata); end
    end
  endtask

  initial begin
    test_reset();
    test_store();
    test_bad_addr();
    test_fill();
    test_clear();
    test_same_cycle();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/display_bank_ctrl.md
Name: display_bank_ctrl

Overview:
Parametrised memory-mapped controller for a bank of display channels on the RISC-V core's store path. It replaces per-store combinational strobes with registered per-channel shadow words. It adds a multi-cycle broadcast clear sweep with busy/ready back-pressure. It adds a round-robin dirty-channel scan-out port with valid/ready handshake, feeding display refresh logic.

Parameters:
NUM_CH, 16, number of display channels (1..256); CH_W = max(1, clog2(NUM_CH))
DATA_W, 32, store data width (>= 9)
BASE_ADDR, 32'h0, byte address of channel 0
ADDR_STRIDE, 4, byte stride between channels (power of two)
CLEAR_ADDR, 32'h1800, byte address that triggers the broadcast clear

Ports:
clk  in  1  clock; all state on rising edge
rst  in  1  reset, asynchronous, active-high
wr_en  in  1  store strobe
wr_addr  in  32  store byte address
wr_data  in  DATA_W  store data
wr_ready  out  1  high when a store is accepted this cycle (= !busy)
busy  out  1  clear sweep in progress
ch_out  out  NUM_CH*DATA_W  flattened channel words; channel i at [i*DATA_W +: DATA_W]
ch_dirty  out  NUM_CH  per-channel changed-since-last-scan flags
scan_valid  out  1  scan entry presented
scan_ready  in  1  consumer accepts the entry
scan_ch  out  CH_W  channel index of the presented entry
scan_data  out  DATA_W  snapshot of ch_out for scan_ch

Behaviour:
- Reset (async): ch_out=0, ch_dirty=0, busy=0, wr_ready=1, scan_valid=0, scan_ch=0, scan_data=0, rr_ptr=0, FSM=IDLE.
- Output word format: a channel store of V writes ((V << 8) | 1) truncated to DATA_W. Bit0=1 marks the channel lit. A cleared channel holds 0.
- Decode, in IDLE with wr_en high:
  - wr_addr==CLEAR_ADDR → start clear; this takes precedence over a channel hit.
  - off = wr_addr-BASE_ADDR. A channel hit requires off%ADDR_STRIDE==0 and off/ADDR_STRIDE < NUM_CH.
  - Any other address is silently ignored.
- Store latency: a store at edge k updates ch_out and sets ch_dirty[ch] from edge k. It is visible in cycle k+1.
- FSM states: IDLE and CLEAR.
  - IDLE→CLEAR on an accepted clear store; the sweep index idx is set to 0.
  - In CLEAR, each cycle: ch_out[idx]=0, ch_dirty[idx]=1, idx++.
  - After idx==NUM_CH-1 is cleared, return to IDLE.
  - busy is high for exactly NUM_CH cycles after the clear edge.
- Stores while busy: wr_ready=0, and the store is dropped, not queued. The CPU holds the store until wr_ready is high.
- Scan port:
  - When scan_valid=0 or a handshake occurs this cycle, the arbiter picks the first dirty channel at or after rr_ptr, with wrap.
  - The picked channel loads scan_ch and scan_data (registered), sets scan_valid=1, and sets rr_ptr=picked+1 mod NUM_CH.
  - Back-to-back entries on consecutive cycles are supported.
  - Presented scan_ch and scan_data stay stable until scan_valid&&scan_ready.
  - On handshake, ch_dirty[scan_ch] clears, unless a store or clear hits that channel in the same cycle. In that case dirty stays 1 and the new value is re-emitted later.
  - No dirty channels → scan_valid drops after the handshake.
- Dirty-set timing: scan latency from a store at edge k is scan_valid high in cycle k+2 at the earliest.
- Scan runs during CLEAR; it emits cleared channels as zeros.
- Simultaneous store and scan pick on the same channel: the scan snapshot takes the pre-store value, and dirty remains set.
- Reset mid-sweep or mid-handshake returns everything to reset values immediately. A partial clear is not resumed.

Decomposition:
- Package display_pkg:
  - state enum {IDLE, CLEAR};
  - default CLEAR_ADDR constant;
  - function fmt_word(V) returning (V<<8)|1;
  - function ch_decode(addr) returning {hit, ch}.
- Sub-module rr_dirty_arbiter (inputs: dirty vector, rr_ptr; outputs: found, idx). It is purely combinational, rotate-then-priority-encode, reused by other bank controllers.

Test Plan:
- Reset, then store 0xAB to BASE+8 → ch_out[2]=0x0000AB01 in the next cycle; ch_dirty=0x0004; scan_valid two cycles after the store; scan_ch=2; scan_data=0x0000AB01.
- Stores to BASE+2 (misaligned) and BASE+4*NUM_CH → ch_out and ch_dirty unchanged; wr_ready remains 1.
- Fill all 16 channels, hold scan_ready=1 → 16 consecutive entries, ch 0..15 in order; then scan_valid=0 and ch_dirty=0.
- Store to 0x1800 → busy=1 and wr_ready=0 for 16 cycles; all ch_out=0. A store to channel 3 issued mid-sweep is dropped; after busy falls, 16 zero entries are scannable.
- Hold scan_ready=0 on presented ch 5; store 0x7 to ch 5 and handshake in the same cycle → the accepted entry carries the old value, ch_dirty[5] stays 1, and the next entry for ch 5 is 0x00000701.
- Assert rst asynchronously at sweep cycle 7 → all outputs are at reset values before the next edge; wr_ready=1 after deassert.
